// File: rtl/bit_serializer.sv
// Bit serializer: queues {data, len, order} words in a FIFO and shifts each out one bit per cycle.
// Latency: when idle with an empty FIFO, the first bit is on valid_o two cycles after the accepting edge.
// Backpressure: in_ready is registered and is low while the FIFO holds FIFO_DEPTH words.
module bit_serializer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic [3:0]       in_len,
  input  logic             msb_first,
  input  logic [1:0]       idle_gap,
  output logic             d_o,
  output logic             valid_o,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = 13;  // {data[7:0], len[3:0], msb_first}

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  // FIFO storage and bookkeeping
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          r_in_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_nempty;
  logic [3:0]    w_len_eff;
  logic [EW-1:0] w_head;
  logic [7:0]    w_head_data;
  logic [7:0]    w_head_rev;
  logic [3:0]    w_head_len;
  logic          w_head_msb;

  // Serializer state
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_last;
  logic             w_gap_go;
  logic [7:0]       r_shift;
  logic [3:0]       r_bit_cnt;
  logic [1:0]       r_gap_cnt;
  logic             r_d_o;
  logic             r_valid_o;
  logic [CNT_W-1:0] r_word_cnt;

  // Lengths of 0 or above 8 collapse to a full byte before they are stored.
  assign w_len_eff = (in_len == 4'd0 || in_len > 4'd8) ? 4'd8 : in_len;

  // in_ready is a registered view of the count, so a push can never land on a full FIFO.
  assign w_push   = in_valid & r_in_ready & ~rst;
  assign w_nempty = (r_count != '0);

  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_data = w_head[12:5];
  assign w_head_len  = w_head[4:1];
  assign w_head_msb  = w_head[0];

  // LSB-first words are bit-reversed on load so the shifter always emits its top bit.
  always_comb begin
    w_head_rev = '0;
    for (int i = 0; i < 8; i++) begin
      w_head_rev[i] = w_head_data[7-i];
    end
  end

  // Next FIFO occupancy: push and pop together leave it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // FIFO entry write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_data, w_len_eff, msb_first};
    end
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt < CW'(FIFO_DEPTH));
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and load decisions; a gap request outranks chaining the next word.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_last      = 1'b0;
    w_gap_go    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_nempty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_bit_cnt == 4'd1) begin
          w_last = 1'b1;
          if (idle_gap != 2'd0) begin
            w_gap_go    = 1'b1;
            w_state_nxt = S_GAP;
          end else if (w_nempty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_SHIFT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_GAP: begin
        // The final gap cycle acts as IDLE so the next word starts without an extra bubble.
        if (r_gap_cnt == 2'd1) begin
          if (w_nempty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_SHIFT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Shifter, bit/gap counters, registered serial outputs and completed-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_d_o      <= 1'b0;
      r_valid_o  <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_valid_o <= (r_state == S_SHIFT);
      r_d_o     <= (r_state == S_SHIFT) & r_shift[7];
      if (w_pop) begin
        r_shift   <= w_head_msb ? w_head_data : w_head_rev;
        r_bit_cnt <= w_head_len;
      end else if (r_state == S_SHIFT) begin
        r_shift   <= {r_shift[6:0], 1'b0};
        r_bit_cnt <= r_bit_cnt - 4'd1;
      end
      if (w_gap_go) begin
        r_gap_cnt <= idle_gap;
      end else if (r_state == S_GAP) begin
        r_gap_cnt <= r_gap_cnt - 2'd1;
      end
      if (w_last) begin
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready = r_in_ready;
  assign d_o      = r_d_o;
  assign valid_o  = r_valid_o;
  assign busy     = (r_state != S_IDLE) || w_nempty;
  assign word_cnt = r_word_cnt;

endmodule

// File: tb/tb_bit_serializer.sv
// Testbench for bit_serializer: schedule-based reference model plus directed literal cases.
// Latency: outputs compared every cycle on the falling edge once reset has been applied.
// Backpressure: the model tracks FIFO occupancy to predict in_ready.
module tb_bit_serializer;

  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          in_valid  = 1'b0;
  logic [7:0]    in_data   = '0;
  logic [3:0]    in_len    = '0;
  logic          msb_first = 1'b0;
  logic [1:0]    idle_gap  = '0;
  logic          in_ready;
  logic          d_o;
  logic          valid_o;
  logic          busy;
  logic [CW-1:0] word_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  bit cap_bits[$];
  int cap_cyc[$];
  int last_acc = 0;
  int n_push   = 0;
  int low_at   = -1;

  bit_serializer #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_len(in_len), .msb_first(msb_first), .idle_gap(idle_gap),
    .d_o(d_o), .valid_o(valid_o), .busy(busy), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] d;
    int         len;
    bit         msb;
    int         acc;
  } word_t;

  word_t q_pend[$];
  word_t cur;
  bit    has_cur   = 1'b0;
  int    cur_s     = 0;
  int    next_free = 0;
  int    gap_end   = 0;
  int    exp_cnt   = 0;
  bit    exp_vld   = 1'b0;
  bit    exp_d     = 1'b0;
  bit    exp_ready = 1'b1;
  bit    exp_busy  = 1'b0;

  // k-th bit put on the wire for a word
  function automatic bit word_bit(input word_t w, input int k);
    if (w.msb) return w.d[7-k];
    return w.d[k];
  endfunction

  // Each word starts at max(accept+2, previous end+1+gap); bits follow back to back.
  always @(posedge clk) begin
    int    cnt_now;
    word_t w;
    cyc++;
    if (rst) begin
      q_pend.delete();
      has_cur   = 1'b0;
      next_free = 0;
      gap_end   = 0;
      exp_cnt   = 0;
      exp_vld   = 1'b0;
      exp_d     = 1'b0;
      exp_ready = 1'b1;
      exp_busy  = 1'b0;
    end else begin
      if (in_valid && exp_ready) begin
        w.d   = in_data;
        w.len = (in_len == 4'd0 || in_len > 4'd8) ? 8 : int'(in_len);
        w.msb = msb_first;
        w.acc = cyc;
        q_pend.push_back(w);
      end
      exp_vld = 1'b0;
      exp_d   = 1'b0;
      if (has_cur && cyc >= cur_s) begin
        exp_vld = 1'b1;
        exp_d   = word_bit(cur, cyc - cur_s);
        if (cyc - cur_s == cur.len - 1) begin
          exp_cnt   = (exp_cnt + 1) % (1 << CW);
          next_free = cyc + 1 + int'(idle_gap);
          gap_end   = cyc + int'(idle_gap);
          has_cur   = 1'b0;
        end
      end
      if (!has_cur && q_pend.size() > 0) begin
        cur     = q_pend.pop_front();
        cur_s   = (cur.acc + 2 > next_free) ? cur.acc + 2 : next_free;
        has_cur = 1'b1;
      end
      cnt_now   = q_pend.size() + ((has_cur && cur_s - 1 > cyc) ? 1 : 0);
      exp_ready = (cnt_now < DEPTH);
      exp_busy  = (cnt_now > 0) || (has_cur && cur_s - 1 <= cyc) || (cyc < gap_end);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle-by-cycle comparison against the model, plus capture of emitted bits.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid_o", valid_o, exp_vld);
      chk("d_o", d_o, exp_d);
      chk("in_ready", in_ready, exp_ready);
      chk("busy", busy, exp_busy);
      chk("word_cnt", word_cnt, exp_cnt);
      if (valid_o) begin
        cap_bits.push_back(d_o);
        cap_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cap_clear();
    cap_bits.delete();
    cap_cyc.delete();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    chk_en   = 1'b1;
    rst      = 1'b0;
    n_push   = 0;
    low_at   = -1;
    cap_clear();
  endtask

  task automatic push(input logic [7:0] d, input logic [3:0] l, input bit m);
    int w;
    w         = 0;
    in_valid  = 1'b1;
    in_data   = d;
    in_len    = l;
    msb_first = m;
    if (!in_ready && low_at < 0) low_at = n_push;
    while (!in_ready && w < 200) begin
      tick();
      w++;
    end
    if (w >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles, required 1", w);
    end
    last_acc = cyc + 1;
    n_push++;
    tick();
  endtask

  task automatic wait_idle();
    int w;
    w        = 0;
    in_valid = 1'b0;
    while ((busy || valid_o) && w < 500) begin
      tick();
      w++;
    end
    if (w >= 500) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout: busy=%0b valid_o=%0b, required both 0", busy, valid_o);
    end
    tick();
    tick();
  endtask

  function automatic logic [31:0] pack(input int from, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], cap_bits[from+i]};
    return v;
  endfunction

  function automatic int span();
    if (cap_cyc.size() == 0) return -1;
    return cap_cyc[cap_cyc.size()-1] - cap_cyc[0];
  endfunction

  // ---------------- test sequence ----------------
  logic [7:0] t5_bytes [6];

  initial begin
    int acc0;
    int rnd;
    t5_bytes = '{8'h11, 8'h2C, 8'h3B, 8'h84, 8'hE5, 8'h6F};

    rst = 1'b1;
    tick();
    do_reset();

    // reset state
    chk("rst_valid_o", valid_o, 0);
    chk("rst_d_o", d_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_in_ready", in_ready, 1);

    // 0xB6 len 5 MSB-first
    push(8'hB6, 4'd5, 1'b1);
    acc0 = last_acc;
    wait_idle();
    chk("t1_nbits", cap_bits.size(), 5);
    chk("t1_bits", pack(0, 5), 32'b10110);
    chk("t1_latency", cap_cyc[0] - acc0, 2);
    chk("t1_span", span(), 4);
    chk("t1_word_cnt", word_cnt, 1);

    // 0xB6 len 5 LSB-first, then len 0 (full byte) LSB-first
    do_reset();
    push(8'hB6, 4'd5, 1'b0);
    push(8'hB6, 4'd0, 1'b0);
    wait_idle();
    chk("t2_nbits", cap_bits.size(), 13);
    chk("t2_bits", pack(0, 13), 32'b01101_01101101);
    chk("t2_span", span(), 12);
    chk("t2_word_cnt", word_cnt, 2);

    // two len-8 words back to back, no bubble
    do_reset();
    push(8'h3C, 4'd8, 1'b1);
    push(8'hA5, 4'd8, 1'b0);
    wait_idle();
    chk("t3_nbits", cap_bits.size(), 16);
    chk("t3_span", span(), 15);
    chk("t3_bits", pack(0, 16), 32'h3CA5);
    chk("t3_word_cnt", word_cnt, 2);

    // gap of 3 between two len-4 words
    do_reset();
    idle_gap = 2'd3;
    push(8'hF0, 4'd4, 1'b1);
    push(8'h50, 4'd4, 1'b1);
    wait_idle();
    idle_gap = 2'd0;
    chk("t4_bits", pack(0, 8), 32'b1111_0101);
    chk("t4_gap", cap_cyc[4] - cap_cyc[3], 4);
    chk("t4_word_cnt", word_cnt, 2);

    // six words offered continuously into a 4-deep FIFO
    do_reset();
    for (int i = 0; i < 6; i++) push(t5_bytes[i], 4'd8, 1'b1);
    wait_idle();
    chk("t5_ready_drop_after", low_at, 5);
    chk("t5_nbits", cap_bits.size(), 48);
    for (int i = 0; i < 6; i++) chk("t5_byte", pack(8*i, 8), {24'h0, t5_bytes[i]});
    chk("t5_word_cnt", word_cnt, 6);

    // reset on the 3rd bit of a word with two words queued
    do_reset();
    push(8'hFF, 4'd8, 1'b1);
    acc0 = last_acc;
    push(8'hAA, 4'd8, 1'b1);
    push(8'h55, 4'd8, 1'b1);
    in_valid = 1'b0;
    while (cyc + 1 < acc0 + 4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_valid_o", valid_o, 0);
    chk("t6_busy", busy, 0);
    chk("t6_word_cnt", word_cnt, 0);
    for (int i = 0; i < 30; i++) tick();
    chk("t6_nbits", cap_bits.size(), 2);
    chk("t6_word_cnt_after", word_cnt, 0);

    // word counter wraps at 2^CW
    do_reset();
    for (int i = 0; i < 17; i++) push(8'h80, 4'd1, 1'b1);
    wait_idle();
    chk("t7_nbits", cap_bits.size(), 17);
    chk("t7_word_cnt_wrap", word_cnt, 1);

    // randomized traffic, gaps and occasional resets
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      rnd       = int'($urandom_range(0, 3));
      in_valid  = (rnd != 0);
      in_data   = 8'($urandom_range(0, 255));
      in_len    = 4'($urandom_range(0, 15));
      msb_first = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) idle_gap = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning input word FIFO entries (power of two, >=2).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning width of the completed-word counter.
REQ-003 The block SHALL have port clk, input, 1, the clock; all logic on rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset; synchronous, active-high.
REQ-005 The block SHALL have port in_valid, input, 1, meaning a word is offered.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the FIFO can accept a word.
REQ-007 The block SHALL have port in_data, input, 8, the parallel word.
REQ-008 The block SHALL have port in_len, input, 4, the number of bits to emit; 1..8 used as-is, 0 or >8 means 8.
REQ-009 The block SHALL have port msb_first, input, 1: 1 emits bit (len-1) down to bit 0 of the selected field, 0 emits bit 0 upward.
REQ-010 The block SHALL have port idle_gap, input, 2, the idle cycles inserted after each word.
REQ-011 The block SHALL have port d_o, output, 1, the serial data bit, feeding a downstream d_i.
REQ-012 The block SHALL have port valid_o, output, 1, the bit qualifier, feeding a downstream valid_i.
REQ-013 The block SHALL have port busy, output, 1, high when the FSM is not IDLE or the FIFO is non-empty.
REQ-014 The block SHALL have port word_cnt, output, CNT_W, the count of fully emitted words.

Function
REQ-015 A word SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; {in_data, in_len, msb_first} are captured together.
REQ-016 For MSB-first, the emitted field SHALL be in_data[7 -: len]; for LSB-first, it SHALL be in_data[0 +: len].
REQ-017 in_ready SHALL be registered and SHALL equal (FIFO count < FIFO_DEPTH); it SHALL NOT depend combinationally on a same-cycle pop.
REQ-018 A simultaneous push and pop SHALL leave the FIFO count unchanged; a push while full SHALL be impossible by construction.
REQ-019 The FSM SHALL have states IDLE, SHIFT and GAP.
REQ-020 IDLE with FIFO non-empty: the FSM SHALL pop the head, load the shift register and bit counter, and go to SHIFT.
REQ-021 SHIFT SHALL assert valid_o=1 with one bit on d_o per cycle, exactly len cycles per word.
REQ-022 On the last bit, the FSM SHALL take the first applicable branch: idle_gap>0 -> GAP, with the gap value sampled at this edge; FIFO non-empty -> load the next word with no bubble; otherwise -> IDLE.
REQ-023 GAP SHALL hold valid_o=0 for exactly the sampled idle_gap cycles, then behave as IDLE.
REQ-024 Latency: with the block idle and the FIFO empty, valid_o SHALL assert for the first bit exactly 2 cycles after the accepting edge.
REQ-025 d_o SHALL be 0 whenever valid_o=0.
REQ-026 word_cnt SHALL increment on the edge that emits a word's last bit and SHALL wrap from 2^CNT_W-1 to 0.
REQ-027 idle_gap changes SHALL affect only gaps sampled after the change.

Reset
REQ-028 On rst=1 at a rising edge: FIFO emptied, FSM to IDLE, shift register and bit counter cleared.
REQ-029 On that same edge: d_o=0, valid_o=0, busy=0, word_cnt=0, in_ready=1.
REQ-030 Reset mid-word SHALL abort the word with no further valid_o and no word_cnt increment.
REQ-031 rst SHALL take priority over a same-cycle push.

Verification
REQ-032 0xB6, len 5, MSB-first, gap 0: d_o=1,0,1,1,0 with valid_o high 5 cycles, first bit 2 cycles after accept; word_cnt=1.
REQ-033 0xB6, len 5, LSB-first: d_o=0,1,1,0,1; then len 0 with 0xB6 -> 8 bits 0,1,1,0,1,1,0,1.
REQ-034 Two len-8 words pushed back-to-back, gap 0: 16 consecutive valid_o cycles with no bubble; word_cnt=2.
REQ-035 Gap 3 between two len-4 words: exactly 3 cycles valid_o=0 between the last bit of word 1 and the first bit of word 2.
REQ-036 Six words offered continuously, FIFO_DEPTH=4, len 8: in_ready drops when 4 entries are stored, all 6 words emitted in order, word_cnt=6.
REQ-037 rst on the 3rd bit of a word with 2 words queued: valid_o=0 on the next edge, busy=0, word_cnt=0, no queued word emitted.
